u109_pci_target: RTL and testbench
==================================

Name: u109_pci_target

Overview:
- PCI target-side responder for the AmigaPCI bridge; the counterpart of the bridge's PCI initiator.
- Lets a PCI bus master read or write an Amiga memory window. It claims the cycle with medium DEVSEL#, requests the 68040 bus, runs one local longword transfer, and completes with TRDY#.
- Retries the master with STOP# if the local bus is not granted in time.
- Sits beside the initiator state machine in U109 on the CLK33 domain; parity and AD pad muxing live elsewhere.

Parameters:
- WINDOW_BASE, 32'h0800_0000, base of the claimed memory window.
- WINDOW_BITS, 27, number of low address bits inside the window; AD[31:WINDOW_BITS] is compared against the base.
- GRANT_LIMIT, 12, number of CLK33 clocks after the address phase to wait for BGn before retrying. Must be ≤13 so TRDY#/STOP# occur within the PCI 16-clock rule.

Ports:
- CLK33  in  1  PCI clock; all logic is on its rising edge.
- RESETn  in  1  asynchronous active-low reset.
- FRAMEn  in  1  PCI FRAME#.
- IRDYn  in  1  PCI IRDY#.
- CBEn  in  4  PCI C/BE#.
- AD_IN  in  32  PCI AD sampled from the pads.
- BGn  in  1  68040 bus grant.
- LOCAL_ACK  in  1  one-clock pulse: local transfer done (read data valid on LOCAL_RDATA).
- LOCAL_RDATA  in  32  local read data.
- DEVSELn, TRDYn, STOPn  out  1 each  PCI target controls.
- TARGET_OE  out  1  output enable for DEVSEL#/TRDY#/STOP#.
- AD_OE  out  1  drive AD with read data.
- AD_OUT  out  32  registered read data.
- BRn  out  1  68040 bus request.
- LOCAL_REQ  out  1  level request to the local cycle engine.
- LOCAL_RnW  out  1  1 = read.
- LOCAL_ADDR  out  32  latched address.
- LOCAL_BE  out  4  active-high byte enables (~CBEn from the data phase).
- LOCAL_WDATA  out  32  write data.

Behaviour:
- Reset (asynchronous, RESETn low): state IDLE.
  - DEVSELn, TRDYn, STOPn, BRn = 1.
  - TARGET_OE, AD_OE, LOCAL_REQ = 0.
  - LOCAL_RnW = 1.
  - All data/address registers = 0.
  - Reset mid-cycle abandons the transaction immediately; no turnaround cycle.
- Address phase: in IDLE, FRAMEn sampled 0 while FRAMEn was 1 on the previous clock. Latch AD_IN and CBEn.
- Hit conditions (all required):
  - AD[31:WINDOW_BITS] == WINDOW_BASE[31:WINDOW_BITS].
  - AD[1:0] == 00.
  - Command is one of: 0110 Memory Read, 1100 Memory Read Multiple, 1110 Memory Read Line (read); 0111 Memory Write, 1111 Memory Write and Invalidate (write).
  - Any other command or address: stay IDLE, never drive.
- States:
  - DECODE (clock 1 after address): assert TARGET_OE; drive DEVSELn/TRDYn/STOPn = 1; assert BRn = 0.
  - CLAIM (clock 2, medium decode): DEVSELn = 0, held until BACKOFF.
  - WAIT_GRANT:
    - BGn == 0: go to LOCAL. For a write, also wait for IRDYn == 0, then latch AD_IN into LOCAL_WDATA. Latch ~CBEn into LOCAL_BE at the same point.
    - Grant counter reaches GRANT_LIMIT with BGn high: go to RETRY.
  - LOCAL: LOCAL_REQ = 1 until LOCAL_ACK. On a read, latch LOCAL_RDATA into AD_OUT. Release LOCAL_REQ and BRn on the ACK clock. Go to DATA. Local latency is bounded by the Amiga side; no timeout once LOCAL_REQ is asserted.
  - DATA: TRDYn = 0; AD_OE = 1 for reads. If FRAMEn == 0 (burst attempt), STOPn = 0 in the same clock (disconnect-with-data). Hold until IRDYn == 0 is sampled (transfer), then go to BACKOFF.
  - RETRY: STOPn = 0, TRDYn = 1; BRn released; LOCAL_REQ never asserted. Hold STOPn until FRAMEn == 1, then go to BACKOFF.
  - BACKOFF: one clock driving DEVSELn/TRDYn/STOPn = 1; AD_OE = 0. Then TURN.
  - TURN: TARGET_OE = 0; back to IDLE. A new address phase is accepted on the next clock.
- Boundary conditions:
  - BGn arrives on the same clock as the limit: grant wins.
  - Master abandons the cycle (FRAMEn and IRDYn both 1) before DATA: go to BACKOFF. If LOCAL_REQ is active, finish the local cycle silently first (hold BRn until LOCAL_ACK).
  - STOPn stays asserted while FRAMEn is low after the transfer.
  - AD_OE rises no earlier than clock 2 after the address phase (turnaround guaranteed by medium decode).

Decomposition:
- Shared package (u109_pci_pkg):
  - PCI command codes (CMD_MEM_READ, CMD_MEM_WRITE, CMD_MEM_READ_MULT, CMD_MEM_READ_LINE, CMD_MEM_WRITE_INV).
  - Target state enumeration.
  - GRANT_LIMIT maximum constant (13).
- One sub-module: u109_pci_target_decode. Combinational hit/command/direction decode from the latched address and C/BE#; reused by future I/O-window targets.
- The sequencer, counter and latches stay in u109_pci_target.

Test Plan:
- Memory read at 0x0800_1234 (CBEn=0110), BGn low at clock 3, LOCAL_ACK at clock 5 with 0xDEADBEEF -> DEVSELn low at clock 2; TRDYn low at clock 6 with AD_OUT = 0xDEADBEEF; TARGET_OE low by clock 9.
- Memory write at 0x0800_0010, data 0x12345678, CBEn=0011 in the data phase -> LOCAL_RnW = 0, LOCAL_WDATA = 0x12345678, LOCAL_BE = 1100; TRDYn only after LOCAL_ACK.
- BGn held high -> STOPn low with TRDYn high at clock GRANT_LIMIT+1; BRn released; LOCAL_REQ never asserts.
- Burst read with FRAMEn kept low -> STOPn and TRDYn low together; STOPn held until FRAMEn high; exactly one LOCAL_REQ.
- Address 0x1000_0000, or I/O read command 0010 -> no DEVSELn, TARGET_OE stays 0.
- RESETn pulsed low in LOCAL state -> all outputs return to reset values asynchronously; the next address phase is decoded normally.

Source files
------------

// File: rtl/u109_pci_pkg.sv
// Shared definitions for the U109 PCI target: command codes, sequencer states
// and the upper bound on the bus-grant wait.
package u109_pci_pkg;

    localparam logic [3:0] CMD_MEM_READ      = 4'b0110;
    localparam logic [3:0] CMD_MEM_WRITE     = 4'b0111;
    localparam logic [3:0] CMD_MEM_READ_MULT = 4'b1100;
    localparam logic [3:0] CMD_MEM_READ_LINE = 4'b1110;
    localparam logic [3:0] CMD_MEM_WRITE_INV = 4'b1111;

    // Beyond 13 clocks of grant wait, TRDY#/STOP# would miss the 16-clock limit.
    localparam int GRANT_LIMIT_MAX = 13;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_DECODE,
        ST_CLAIM,
        ST_WAIT_GRANT,
        ST_LOCAL,
        ST_DATA,
        ST_RETRY,
        ST_BACKOFF,
        ST_TURN
    } target_state_e;

endpackage

// File: rtl/u109_pci_target_decode.sv
// Combinational memory-window hit and direction decode for a PCI address phase.
module u109_pci_target_decode
    import u109_pci_pkg::*;
#(
    parameter logic [31:0] WINDOW_BASE = 32'h0800_0000,
    parameter int          WINDOW_BITS = 27
) (
    input  logic [31:0] addr_i,
    input  logic [3:0]  cmd_i,
    output logic        hit_o,
    output logic        is_read_o
);

    logic cmd_read;
    logic cmd_write;
    logic addr_match;

    always_comb begin
        cmd_read   = (cmd_i == CMD_MEM_READ) || (cmd_i == CMD_MEM_READ_MULT) ||
                     (cmd_i == CMD_MEM_READ_LINE);
        cmd_write  = (cmd_i == CMD_MEM_WRITE) || (cmd_i == CMD_MEM_WRITE_INV);
        addr_match = (addr_i[31:WINDOW_BITS] == WINDOW_BASE[31:WINDOW_BITS]);
        hit_o      = addr_match && (addr_i[1:0] == 2'b00) && (cmd_read || cmd_write);
        is_read_o  = cmd_read;
    end

endmodule

// File: rtl/u109_pci_target.sv
// PCI target for the AmigaPCI bridge: claims memory-window cycles with medium
// DEVSEL#, runs one local longword transfer on the 68040 bus, or retries.
module u109_pci_target
    import u109_pci_pkg::*;
#(
    parameter logic [31:0] WINDOW_BASE = 32'h0800_0000,
    parameter int          WINDOW_BITS = 27,
    parameter int          GRANT_LIMIT = 12
) (
    input  logic        CLK33,
    input  logic        RESETn,
    input  logic        FRAMEn,
    input  logic        IRDYn,
    input  logic [3:0]  CBEn,
    input  logic [31:0] AD_IN,
    input  logic        BGn,
    input  logic        LOCAL_ACK,
    input  logic [31:0] LOCAL_RDATA,
    output logic        DEVSELn,
    output logic        TRDYn,
    output logic        STOPn,
    output logic        TARGET_OE,
    output logic        AD_OE,
    output logic [31:0] AD_OUT,
    output logic        BRn,
    output logic        LOCAL_REQ,
    output logic        LOCAL_RnW,
    output logic [31:0] LOCAL_ADDR,
    output logic [3:0]  LOCAL_BE,
    output logic [31:0] LOCAL_WDATA
);

    localparam int LIMIT = (GRANT_LIMIT > GRANT_LIMIT_MAX) ? GRANT_LIMIT_MAX : GRANT_LIMIT;

    target_state_e state_q, state_d;
    logic          frame_prev_q, frame_prev_d;
    logic [31:0]   addr_q, addr_d;
    logic          rnw_q, rnw_d;
    logic [3:0]    be_q, be_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          abort_q, abort_d;

    logic dec_hit;
    logic dec_read;
    logic abandon;
    logic go_local;

    // Decoded straight from the pads on the address clock, as the values are latched.
    u109_pci_target_decode #(
        .WINDOW_BASE (WINDOW_BASE),
        .WINDOW_BITS (WINDOW_BITS)
    ) u_decode (
        .addr_i    (AD_IN),
        .cmd_i     (CBEn),
        .hit_o     (dec_hit),
        .is_read_o (dec_read)
    );

    always_ff @(posedge CLK33 or negedge RESETn) begin
        if (!RESETn) begin
            state_q      <= ST_IDLE;
            frame_prev_q <= 1'b1;
            addr_q       <= '0;
            rnw_q        <= 1'b1;
            be_q         <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            cnt_q        <= '0;
            abort_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_prev_q <= frame_prev_d;
            addr_q       <= addr_d;
            rnw_q        <= rnw_d;
            be_q         <= be_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            cnt_q        <= cnt_d;
            abort_q      <= abort_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        frame_prev_d = FRAMEn;
        addr_d       = addr_q;
        rnw_d        = rnw_q;
        be_d         = be_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        cnt_d        = cnt_q;
        abort_d      = abort_q;
        abandon      = FRAMEn && IRDYn;
        // Writes need the master's data on AD before the local cycle can start.
        go_local     = !BGn && (rnw_q || !IRDYn);

        case (state_q)
            ST_IDLE: begin
                if (frame_prev_q && !FRAMEn) begin
                    addr_d = AD_IN;
                    if (dec_hit) begin
                        rnw_d   = dec_read;
                        cnt_d   = 4'd1;
                        abort_d = 1'b0;
                        state_d = ST_DECODE;
                    end
                end
            end
            ST_DECODE: begin
                cnt_d   = cnt_q + 4'd1;
                state_d = abandon ? ST_BACKOFF : ST_CLAIM;
            end
            ST_CLAIM: begin
                cnt_d   = cnt_q + 4'd1;
                state_d = abandon ? ST_BACKOFF : ST_WAIT_GRANT;
            end
            ST_WAIT_GRANT: begin
                cnt_d = cnt_q + 4'd1;
                if (abandon) begin
                    state_d = ST_BACKOFF;
                end else if (go_local) begin
                    be_d = ~CBEn;
                    if (!rnw_q) begin
                        wdata_d = AD_IN;
                    end
                    state_d = ST_LOCAL;
                end else if (cnt_q >= 4'(LIMIT)) begin
                    state_d = ST_RETRY;
                end
            end
            ST_LOCAL: begin
                if (abandon) begin
                    abort_d = 1'b1;
                end
                if (LOCAL_ACK) begin
                    if (rnw_q) begin
                        rdata_d = LOCAL_RDATA;
                    end
                    state_d = (abort_q || abandon) ? ST_BACKOFF : ST_DATA;
                end
            end
            ST_DATA: begin
                if (!IRDYn) begin
                    state_d = FRAMEn ? ST_BACKOFF : ST_RETRY;
                end
            end
            ST_RETRY: begin
                if (FRAMEn) begin
                    state_d = ST_BACKOFF;
                end
            end
            ST_BACKOFF: state_d = ST_TURN;
            ST_TURN:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        TARGET_OE = (state_q != ST_IDLE) && (state_q != ST_TURN);
        DEVSELn   = !((state_q == ST_CLAIM) || (state_q == ST_WAIT_GRANT) ||
                      (state_q == ST_LOCAL) || (state_q == ST_DATA) || (state_q == ST_RETRY));
        TRDYn     = (state_q != ST_DATA);
        // A burst attempt is disconnected in the same clock as its first data.
        STOPn     = !((state_q == ST_RETRY) || ((state_q == ST_DATA) && !FRAMEn));
        AD_OE     = (state_q == ST_DATA) && rnw_q;
        BRn       = !((state_q == ST_DECODE) || (state_q == ST_CLAIM) ||
                      (state_q == ST_WAIT_GRANT) || (state_q == ST_LOCAL));
        LOCAL_REQ = (state_q == ST_LOCAL);
    end

    assign AD_OUT      = rdata_q;
    assign LOCAL_RnW   = rnw_q;
    assign LOCAL_ADDR  = addr_q;
    assign LOCAL_BE    = be_q;
    assign LOCAL_WDATA = wdata_q;

endmodule

// File: tb/tb_u109_pci_target.sv
// Directed bench for u109_pci_target: read, write, retry, grant-at-limit,
// burst disconnect, decode misses, abandon and mid-cycle reset.
module tb_u109_pci_target;

    logic        CLK33 = 1'b0;
    logic        RESETn;
    logic        FRAMEn, IRDYn, BGn, LOCAL_ACK;
    logic [3:0]  CBEn;
    logic [31:0] AD_IN, LOCAL_RDATA;
    logic        DEVSELn, TRDYn, STOPn, TARGET_OE, AD_OE, BRn, LOCAL_REQ, LOCAL_RnW;
    logic [31:0] AD_OUT, LOCAL_ADDR, LOCAL_WDATA;
    logic [3:0]  LOCAL_BE;

    int n_cmp = 0;
    int n_bad = 0;
    int req_rises = 0;
    logic req_prev = 1'b0;

    u109_pci_target dut (
        .CLK33(CLK33), .RESETn(RESETn), .FRAMEn(FRAMEn), .IRDYn(IRDYn), .CBEn(CBEn),
        .AD_IN(AD_IN), .BGn(BGn), .LOCAL_ACK(LOCAL_ACK), .LOCAL_RDATA(LOCAL_RDATA),
        .DEVSELn(DEVSELn), .TRDYn(TRDYn), .STOPn(STOPn), .TARGET_OE(TARGET_OE),
        .AD_OE(AD_OE), .AD_OUT(AD_OUT), .BRn(BRn), .LOCAL_REQ(LOCAL_REQ),
        .LOCAL_RnW(LOCAL_RnW), .LOCAL_ADDR(LOCAL_ADDR), .LOCAL_BE(LOCAL_BE),
        .LOCAL_WDATA(LOCAL_WDATA)
    );

    always #5 CLK33 = ~CLK33;

    always @(negedge CLK33) begin
        if (LOCAL_REQ && !req_prev) req_rises++;
        req_prev = LOCAL_REQ;
    end

    // Cycle k of a transaction is the period after the k-th rising edge.
    task automatic step();
        @(posedge CLK33);
        #2;
    endtask

    task automatic bus_idle();
        FRAMEn = 1'b1; IRDYn = 1'b1; CBEn = 4'hF; AD_IN = '0;
        BGn = 1'b1; LOCAL_ACK = 1'b0; LOCAL_RDATA = '0;
    endtask

    task automatic addr_phase(input logic [31:0] a, input logic [3:0] cmd);
        FRAMEn = 1'b0; AD_IN = a; CBEn = cmd;
        step();
    endtask

    task automatic test_reset();
        RESETn = 1'b0;
        bus_idle();
        step(); step();
        n_cmp++;
        if ({DEVSELn, TRDYn, STOPn, BRn, TARGET_OE, AD_OE, LOCAL_REQ, LOCAL_RnW} !== 8'b1111_0001) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b want 11110001",
                     {DEVSELn, TRDYn, STOPn, BRn, TARGET_OE, AD_OE, LOCAL_REQ, LOCAL_RnW});
        end
        n_cmp++;
        if ({AD_OUT, LOCAL_ADDR, LOCAL_WDATA, LOCAL_BE} !== '0) begin
            n_bad++;
            $display("FAIL reset_data: got %h %h %h %h want zeros", AD_OUT, LOCAL_ADDR, LOCAL_WDATA, LOCAL_BE);
        end
        RESETn = 1'b1;
        step(); step();
        $display("reset checked");
    endtask

    task automatic test_read(input logic [31:0] a, input logic [31:0] d);
        addr_phase(a, 4'b0110);                       // cycle 1
        FRAMEn = 1'b1; IRDYn = 1'b0; CBEn = 4'b0000; AD_IN = '0;
        n_cmp++;
        if (TARGET_OE !== 1'b1 || DEVSELn !== 1'b1 || BRn !== 1'b0) begin
            n_bad++;
            $display("FAIL rd_decode: oe/devsel/br got %b%b%b want 110", TARGET_OE, DEVSELn, BRn);
        end
        step();                                       // cycle 2
        n_cmp++;
        if (DEVSELn !== 1'b0 || AD_OE !== 1'b0) begin
            n_bad++;
            $display("FAIL rd_claim: devsel/ad_oe got %b%b want 00", DEVSELn, AD_OE);
        end
        step(); BGn = 1'b0;                           // cycle 3
        step();                                       // cycle 4
        n_cmp++;
        if (LOCAL_REQ !== 1'b1 || LOCAL_RnW !== 1'b1 || LOCAL_ADDR !== a) begin
            n_bad++;
            $display("FAIL rd_local: req/rnw got %b%b addr %h want 11 %h", LOCAL_REQ, LOCAL_RnW, LOCAL_ADDR, a);
        end
        step(); LOCAL_ACK = 1'b1; LOCAL_RDATA = d;    // cycle 5
        step(); LOCAL_ACK = 1'b0; BGn = 1'b1;         // cycle 6
        #1;
        n_cmp++;
        if (TRDYn !== 1'b0 || STOPn !== 1'b1 || AD_OE !== 1'b1 || AD_OUT !== d) begin
            n_bad++;
            $display("FAIL rd_data: trdy/stop/ad_oe got %b%b%b data %h want 011 %h", TRDYn, STOPn, AD_OE, AD_OUT, d);
        end
        n_cmp++;
        if (LOCAL_REQ !== 1'b0 || BRn !== 1'b1 || LOCAL_BE !== 4'b1111) begin
            n_bad++;
            $display("FAIL rd_release: req/br got %b%b be %b want 01 1111", LOCAL_REQ, BRn, LOCAL_BE);
        end
        step(); IRDYn = 1'b1;                         // cycle 7 backoff
        n_cmp++;
        if (TRDYn !== 1'b1 || DEVSELn !== 1'b1 || TARGET_OE !== 1'b1 || AD_OE !== 1'b0) begin
            n_bad++;
            $display("FAIL rd_backoff: trdy/devsel/oe/ad_oe got %b%b%b%b want 1110", TRDYn, DEVSELn, TARGET_OE, AD_OE);
        end
        step(); step();                               // cycle 9
        n_cmp++;
        if (TARGET_OE !== 1'b0) begin
            n_bad++;
            $display("FAIL rd_turn: target_oe got %b want 0", TARGET_OE);
        end
        $display("read %h -> %h done", a, d);
    endtask

    task automatic test_write();
        addr_phase(32'h0800_0010, 4'b0111);           // cycle 1
        FRAMEn = 1'b1; IRDYn = 1'b0; CBEn = 4'b0011; AD_IN = 32'h1234_5678;
        step(); step(); BGn = 1'b0;                   // cycle 3
        step();                                       // cycle 4
        n_cmp++;
        if (LOCAL_REQ !== 1'b1 || LOCAL_RnW !== 1'b0 || LOCAL_WDATA !== 32'h1234_5678 || LOCAL_BE !== 4'b1100) begin
            n_bad++;
            $display("FAIL wr_local: req/rnw got %b%b wdata %h be %b want 10 12345678 1100",
                     LOCAL_REQ, LOCAL_RnW, LOCAL_WDATA, LOCAL_BE);
        end
        n_cmp++;
        if (TRDYn !== 1'b1) begin
            n_bad++;
            $display("FAIL wr_trdy_early: got %b want 1", TRDYn);
        end
        step(); LOCAL_ACK = 1'b1;                     // cycle 5
        n_cmp++;
        if (TRDYn !== 1'b1) begin
            n_bad++;
            $display("FAIL wr_trdy_ack: got %b want 1", TRDYn);
        end
        step(); LOCAL_ACK = 1'b0; BGn = 1'b1;         // cycle 6
        n_cmp++;
        if (TRDYn !== 1'b0 || AD_OE !== 1'b0) begin
            n_bad++;
            $display("FAIL wr_data: trdy/ad_oe got %b%b want 00", TRDYn, AD_OE);
        end
        step(); IRDYn = 1'b1; AD_IN = '0; CBEn = 4'hF;
        step(); step();
        $display("write 08000010 <- 12345678 done");
    endtask

    task automatic test_retry();
        int req_seen = 0;
        addr_phase(32'h0800_0100, 4'b0110);           // cycle 1
        FRAMEn = 1'b1; IRDYn = 1'b0; CBEn = 4'b0000;
        for (int c = 1; c <= 12; c++) begin
            if (LOCAL_REQ !== 1'b0 || STOPn !== 1'b1) req_seen++;
            step();
        end                                           // cycle 13
        n_cmp++;
        if (req_seen != 0) begin
            n_bad++;
            $display("FAIL rt_wait: early req/stop cycles got %0d want 0", req_seen);
        end
        n_cmp++;
        if (STOPn !== 1'b0 || TRDYn !== 1'b1 || BRn !== 1'b1 || LOCAL_REQ !== 1'b0 || DEVSELn !== 1'b0) begin
            n_bad++;
            $display("FAIL rt_stop: stop/trdy/br/req/devsel got %b%b%b%b%b want 01100",
                     STOPn, TRDYn, BRn, LOCAL_REQ, DEVSELn);
        end
        step(); IRDYn = 1'b1;                         // cycle 14 backoff
        n_cmp++;
        if (STOPn !== 1'b1 || DEVSELn !== 1'b1) begin
            n_bad++;
            $display("FAIL rt_backoff: stop/devsel got %b%b want 11", STOPn, DEVSELn);
        end
        step(); step();
        $display("retry on missing grant done");
    endtask

    task automatic test_grant_at_limit();
        addr_phase(32'h0800_0200, 4'b1100);           // cycle 1
        FRAMEn = 1'b1; IRDYn = 1'b0; CBEn = 4'b0000;
        for (int c = 1; c < 12; c++) step();          // cycle 12
        BGn = 1'b0;
        step();                                       // cycle 13
        n_cmp++;
        if (LOCAL_REQ !== 1'b1 || STOPn !== 1'b1) begin
            n_bad++;
            $display("FAIL gl_grant_wins: req/stop got %b%b want 11", LOCAL_REQ, STOPn);
        end
        LOCAL_ACK = 1'b1; LOCAL_RDATA = 32'h0BAD_F00D;
        step(); LOCAL_ACK = 1'b0; BGn = 1'b1;         // data
        n_cmp++;
        if (TRDYn !== 1'b0 || AD_OUT !== 32'h0BAD_F00D) begin
            n_bad++;
            $display("FAIL gl_data: trdy got %b data %h want 0 0badf00d", TRDYn, AD_OUT);
        end
        step(); IRDYn = 1'b1;
        step(); step();
        $display("grant on limit clock done");
    endtask

    task automatic test_burst();
        req_rises = 0;
        addr_phase(32'h0800_0300, 4'b1110);           // cycle 1, FRAMEn stays low
        IRDYn = 1'b0; CBEn = 4'b0000;
        step(); step(); BGn = 1'b0;                   // cycle 3
        step(); step(); LOCAL_ACK = 1'b1; LOCAL_RDATA = 32'hA5A5_5A5A;
        step(); LOCAL_ACK = 1'b0; BGn = 1'b1;         // cycle 6
        n_cmp++;
        if (TRDYn !== 1'b0 || STOPn !== 1'b0 || AD_OUT !== 32'hA5A5_5A5A) begin
            n_bad++;
            $display("FAIL bu_disconnect: trdy/stop got %b%b data %h want 00 a5a55a5a", TRDYn, STOPn, AD_OUT);
        end
        step();                                       // cycle 7
        n_cmp++;
        if (STOPn !== 1'b0 || TRDYn !== 1'b1) begin
            n_bad++;
            $display("FAIL bu_hold1: stop/trdy got %b%b want 01", STOPn, TRDYn);
        end
        step(); FRAMEn = 1'b1;                        // cycle 8
        n_cmp++;
        if (STOPn !== 1'b0) begin
            n_bad++;
            $display("FAIL bu_hold2: stop got %b want 0", STOPn);
        end
        step(); IRDYn = 1'b1;                         // cycle 9 backoff
        n_cmp++;
        if (STOPn !== 1'b1 || req_rises != 1) begin
            n_bad++;
            $display("FAIL bu_end: stop got %b local_req pulses %0d want 1 1", STOPn, req_rises);
        end
        step(); step();
        $display("burst read disconnected done");
    endtask

    task automatic test_miss(input logic [31:0] a, input logic [3:0] cmd);
        int driven = 0;
        addr_phase(a, cmd);
        FRAMEn = 1'b1; IRDYn = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (DEVSELn !== 1'b1 || TARGET_OE !== 1'b0 || BRn !== 1'b1) driven++;
            step();
        end
        IRDYn = 1'b1;
        n_cmp++;
        if (driven != 0) begin
            n_bad++;
            $display("FAIL miss_%h_%b: driven cycles got %0d want 0", a, cmd, driven);
        end
        step();
        $display("miss %h cmd %b ignored", a, cmd);
    endtask

    task automatic test_abandon();
        addr_phase(32'h0800_0400, 4'b0110);           // cycle 1
        FRAMEn = 1'b1; IRDYn = 1'b1;
        step();                                       // cycle 2 backoff
        n_cmp++;
        if (DEVSELn !== 1'b1 || TARGET_OE !== 1'b1 || BRn !== 1'b1) begin
            n_bad++;
            $display("FAIL ab_backoff: devsel/oe/br got %b%b%b want 111", DEVSELn, TARGET_OE, BRn);
        end
        step();
        n_cmp++;
        if (TARGET_OE !== 1'b0) begin
            n_bad++;
            $display("FAIL ab_turn: target_oe got %b want 0", TARGET_OE);
        end
        step();
        $display("abandoned read done");
    endtask

    task automatic test_reset_mid();
        addr_phase(32'h0800_0500, 4'b0110);
        FRAMEn = 1'b1; IRDYn = 1'b0; CBEn = 4'b0000;
        step(); step(); BGn = 1'b0;
        step();                                       // cycle 4 LOCAL
        #1 RESETn = 1'b0;
        #1;
        n_cmp++;
        if ({DEVSELn, TRDYn, STOPn, BRn, TARGET_OE, AD_OE, LOCAL_REQ, LOCAL_RnW} !== 8'b1111_0001 ||
            LOCAL_ADDR !== 32'h0) begin
            n_bad++;
            $display("FAIL rm_async: ctrl got %b addr %h want 11110001 0",
                     {DEVSELn, TRDYn, STOPn, BRn, TARGET_OE, AD_OE, LOCAL_REQ, LOCAL_RnW}, LOCAL_ADDR);
        end
        bus_idle();
        step();
        RESETn = 1'b1;
        step();
        $display("reset in local state done");
        test_read(32'h0800_0600, 32'hCAFE_F00D);
    endtask

    initial begin
        test_reset();
        test_read(32'h0800_1234, 32'hDEAD_BEEF);
        test_write();
        test_retry();
        test_grant_at_limit();
        test_burst();
        test_miss(32'h1000_0000, 4'b0110);
        test_miss(32'h0800_0000, 4'b0010);
        test_abandon();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
